// File: rtl/mips32.sv
// Single-cycle 32-bit MIPS-style load/store CPU: instruction memory, register file,
// ALU, data memory and PC/branch logic, one instruction per rising edge of clk_x.

module mips32_imem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_x,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [31:0]   wdata,
    input  logic [AW-1:0] addr,
    output logic [31:0]   instr
);
    logic [31:0] mem [0:DEPTH-1];

    // Loader write port; the core itself never writes instruction memory.
    always_ff @(posedge clk_x) begin
        if (we) mem[waddr] <= wdata;
    end

    assign instr = mem[addr];
endmodule

module mips32_regfile (
    input  logic        clk_x,
    input  logic        rst,
    input  logic [4:0]  addr_a,
    input  logic [4:0]  addr_b,
    input  logic [4:0]  addr_c,
    output logic [31:0] rdata_a,
    output logic [31:0] rdata_b,
    output logic [31:0] rdata_c,
    input  logic        we,
    input  logic [4:0]  waddr,
    input  logic [31:0] wdata
);
    logic [31:0] reg_b [0:31];

    // reg_b[0] is never written, so it always reads as zero.
    always_ff @(posedge clk_x or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < 32; i++) reg_b[i] <= '0;
        end else if (we && waddr != 5'd0) begin
            reg_b[waddr] <= wdata;
        end
    end

    assign rdata_a = reg_b[addr_a];
    assign rdata_b = reg_b[addr_b];
    assign rdata_c = reg_b[addr_c];
endmodule

module mips32_dmem #(
    parameter int DEPTH = 1024,
    parameter int AW    = 10
) (
    input  logic          clk_x,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [31:0]   wdata,
    output logic [31:0]   rdata
);
    logic [31:0] data [0:DEPTH-1];

    always_ff @(posedge clk_x) begin
        if (we) data[addr] <= wdata;
    end

    assign rdata = data[addr];
endmodule

module mips32 #(
    parameter int IMEM_DEPTH = 1024,
    parameter int DMEM_DEPTH = 1024
) (
    input  logic clk_x,
    input  logic rst
);
    localparam int IAW = (IMEM_DEPTH > 1) ? $clog2(IMEM_DEPTH) : 1;
    localparam int DAW = (DMEM_DEPTH > 1) ? $clog2(DMEM_DEPTH) : 1;

    logic [IAW-1:0] pc_reg, pc_next;
    logic           halted_reg;

    logic [31:0] instr;
    logic [5:0]  op;
    logic [4:0]  ra, rb, rc;
    logic [15:0] imm;
    logic [31:0] sext;

    logic [31:0] ra_val, rb_val, rc_val;
    logic [31:0] opb, alu_result, wb_val, ea, target;
    logic [31:0] dmem_rdata;
    logic [DAW-1:0] dmem_addr;

    logic is_alu, is_lw, is_sw, is_beqz, is_bnez, is_hlt;
    logic run, reg_we, mem_we, taken;

    assign op   = instr[31:26];
    assign ra   = instr[25:21];
    assign rb   = instr[20:16];
    assign rc   = instr[15:11];
    assign imm  = instr[15:0];
    assign sext = {{16{imm[15]}}, imm};

    mips32_imem #(.DEPTH(IMEM_DEPTH), .AW(IAW)) i_f (
        .clk_x (clk_x),
        .we    (1'b0),
        .waddr ('0),
        .wdata ('0),
        .addr  (pc_reg),
        .instr (instr)
    );

    mips32_regfile id (
        .clk_x   (clk_x),
        .rst     (rst),
        .addr_a  (ra),
        .addr_b  (rb),
        .addr_c  (rc),
        .rdata_a (ra_val),
        .rdata_b (rb_val),
        .rdata_c (rc_val),
        .we      (reg_we),
        .waddr   (ra),
        .wdata   (wb_val)
    );

    mips32_dmem #(.DEPTH(DMEM_DEPTH), .AW(DAW)) max (
        .clk_x (clk_x),
        .we    (mem_we),
        .addr  (dmem_addr),
        .wdata (ra_val),
        .rdata (dmem_rdata)
    );

    assign is_alu  = ~op[5];
    assign is_lw   = (op == 6'h30);
    assign is_sw   = (op == 6'h31);
    assign is_beqz = (op == 6'h34);
    assign is_bnez = (op == 6'h35);
    assign is_hlt  = (op == 6'h3F);

    // op[4] picks the sign-extended immediate over R[rc] as second operand.
    assign opb = op[4] ? sext : rc_val;

    always_comb begin
        alu_result = '0;
        case (op[3:0])
            4'h0: alu_result = rb_val + opb;
            4'h1: alu_result = rb_val - opb;
            4'h2: alu_result = rb_val & opb;
            4'h3: alu_result = rb_val | opb;
            4'h4: alu_result = rb_val ^ opb;
            4'h5: alu_result = {31'd0, $signed(rb_val) < $signed(opb)};
            4'h6: alu_result = rb_val << opb[4:0];
            4'h7: alu_result = rb_val >> opb[4:0];
            default: alu_result = '0;
        endcase
    end

    assign run    = ~halted_reg;
    assign reg_we = rst & run & (is_alu | is_lw);
    assign mem_we = rst & run & is_sw;
    assign wb_val = is_lw ? dmem_rdata : alu_result;

    assign ea        = rb_val + sext;
    assign dmem_addr = DAW'(ea % 32'(DMEM_DEPTH));

    assign taken   = (is_beqz & (ra_val == 32'd0)) | (is_bnez & (ra_val != 32'd0));
    assign target  = 32'(pc_reg) + 32'd1 + (taken ? sext : 32'd0);
    assign pc_next = (halted_reg | is_hlt) ? pc_reg : IAW'(target % 32'(IMEM_DEPTH));

    always_ff @(posedge clk_x or negedge rst) begin
        if (!rst) begin
            pc_reg     <= '0;
            halted_reg <= 1'b0;
        end else begin
            pc_reg <= pc_next;
            if (is_hlt) halted_reg <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mips32.sv
// Self-checking bench for mips32: directed program sequences, a vector table of
// single instructions, and random programs compared against an ISA-level model.

module tb_mips32;
    localparam int ID = 1024;
    localparam int DD = 1024;

    logic clk_x = 1'b0;
    logic rst   = 1'b0;

    always #5 clk_x = ~clk_x;

    mips32 #(.IMEM_DEPTH(ID), .DMEM_DEPTH(DD)) dut (
        .clk_x (clk_x),
        .rst   (rst)
    );

    int errors = 0;
    int checks = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] enc_r(input logic [5:0] op, input logic [4:0] a,
                                           input logic [4:0] b, input logic [4:0] c);
        return {op, a, b, c, 11'd0};
    endfunction

    function automatic logic [31:0] enc_i(input logic [5:0] op, input logic [4:0] a,
                                           input logic [4:0] b, input logic [15:0] imm);
        return {op, a, b, imm};
    endfunction

    // ISA-level reference model
    logic [31:0] m_imem [ID];
    logic [31:0] m_reg  [32];
    logic [31:0] m_data [DD];
    int          m_pc;
    bit          m_halt;

    function automatic logic [31:0] m_alu(input logic [3:0] f, input logic [31:0] a, input logic [31:0] b);
        case (f)
            4'd0: return a + b;
            4'd1: return a - b;
            4'd2: return a & b;
            4'd3: return a | b;
            4'd4: return a ^ b;
            4'd5: return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd6: return a << b[4:0];
            4'd7: return a >> b[4:0];
            default: return 32'd0;
        endcase
    endfunction

    function automatic void m_step();
        logic [31:0] ins, sx, ea;
        logic [5:0]  op;
        int ra, rb, rc, nxt, idx;
        if (m_halt) return;
        ins = m_imem[m_pc];
        op  = ins[31:26];
        ra  = int'(ins[25:21]);
        rb  = int'(ins[20:16]);
        rc  = int'(ins[15:11]);
        sx  = {{16{ins[15]}}, ins[15:0]};
        nxt = m_pc + 1;
        ea  = m_reg[rb] + sx;
        idx = int'(ea % 32'(DD));
        if (op < 6'h10) begin
            if (ra != 0) m_reg[ra] = m_alu(op[3:0], m_reg[rb], m_reg[rc]);
        end else if (op < 6'h20) begin
            if (ra != 0) m_reg[ra] = m_alu(op[3:0], m_reg[rb], sx);
        end else begin
            case (op)
                6'h30: if (ra != 0) m_reg[ra] = m_data[idx];
                6'h31: m_data[idx] = m_reg[ra];
                6'h34: if (m_reg[ra] == 32'd0) nxt = m_pc + 1 + int'($signed(sx));
                6'h35: if (m_reg[ra] != 32'd0) nxt = m_pc + 1 + int'($signed(sx));
                6'h3F: begin m_halt = 1'b1; nxt = m_pc; end
                default: ;
            endcase
        end
        m_pc = ((nxt % ID) + ID) % ID;
    endfunction

    typedef struct {
        string       name;
        logic [31:0] instr;
        logic [31:0] x;
        logic [31:0] y;
        int          dst;
        logic [31:0] exp_val;
        int          exp_pc;
    } vec_t;

    vec_t vecs[$];

    task automatic clear_mems();
        for (int i = 0; i < ID; i++) dut.i_f.mem[i] = 32'd0;
        for (int i = 0; i < DD; i++) dut.max.data[i] = 32'd0;
    endtask

    initial begin
        logic [31:0] ins;
        int k;

        rst = 1'b0;
        clear_mems();

        // Directed program: loads, add, and-immediate, store, branch, halt
        dut.max.data[1] = 32'h0000_000F;
        dut.max.data[2] = 32'h0000_0003;
        dut.i_f.mem[1]  = 32'hC020_0001;
        dut.i_f.mem[2]  = 32'hC040_0002;
        dut.i_f.mem[3]  = 32'h0061_1000;
        dut.i_f.mem[4]  = 32'h4883_0002;
        dut.i_f.mem[5]  = 32'hC480_0003;
        dut.i_f.mem[6]  = 32'hD000_0005;
        dut.i_f.mem[13] = 32'hFFFF_0005;
        #2;
        check("reset_pc", 32'(dut.pc_reg), 32'd0);
        check("reset_halted", 32'(dut.halted_reg), 32'd0);
        check("reset_r5", dut.id.reg_b[5], 32'd0);
        @(negedge clk_x); rst = 1'b1;
        repeat (6) @(posedge clk_x);
        #1;
        check("prog_r1", dut.id.reg_b[1], 32'h0F);
        check("prog_r2", dut.id.reg_b[2], 32'h03);
        check("prog_r3", dut.id.reg_b[3], 32'h12);
        check("prog_r4", dut.id.reg_b[4], 32'h02);
        check("prog_data3", dut.max.data[3], 32'h02);
        check("prog_pc6", 32'(dut.pc_reg), 32'd6);
        $display("seq prog: pc=%0d r3=0x%08h", dut.pc_reg, dut.id.reg_b[3]);
        @(posedge clk_x); #1;
        check("beqz_taken_pc", 32'(dut.pc_reg), 32'd12);
        @(posedge clk_x); #1;
        check("nop_pc", 32'(dut.pc_reg), 32'd13);
        @(posedge clk_x); #1;
        check("hlt_pc", 32'(dut.pc_reg), 32'd13);
        check("hlt_flag", 32'(dut.halted_reg), 32'd1);
        repeat (4) @(posedge clk_x);
        #1;
        check("halted_pc_frozen", 32'(dut.pc_reg), 32'd13);
        check("halted_r3", dut.id.reg_b[3], 32'h12);
        check("halted_data3", dut.max.data[3], 32'h02);
        $display("seq halt: pc=%0d halted=%0d", dut.pc_reg, dut.halted_reg);

        // Asynchronous reset mid-run, away from any clock edge
        @(negedge clk_x); #2; rst = 1'b0; #1;
        check("areset_pc", 32'(dut.pc_reg), 32'd0);
        check("areset_halted", 32'(dut.halted_reg), 32'd0);
        check("areset_r3", dut.id.reg_b[3], 32'd0);
        check("areset_data3", dut.max.data[3], 32'h02);
        @(posedge clk_x); #1;
        check("inreset_pc_held", 32'(dut.pc_reg), 32'd0);
        check("inreset_r1", dut.id.reg_b[1], 32'd0);
        @(negedge clk_x); rst = 1'b1;
        repeat (3) @(posedge clk_x);
        #1;
        check("rerun_r1", dut.id.reg_b[1], 32'h0F);
        @(negedge clk_x); #1; rst = 1'b0; #1;
        check("midrun_r1", dut.id.reg_b[1], 32'd0);
        check("midrun_pc", 32'(dut.pc_reg), 32'd0);
        @(negedge clk_x); rst = 1'b1;
        repeat (6) @(posedge clk_x);
        #1;
        check("rerun_r3", dut.id.reg_b[3], 32'h12);
        check("rerun_pc", 32'(dut.pc_reg), 32'd6);
        $display("seq reset: pc=%0d r3=0x%08h", dut.pc_reg, dut.id.reg_b[3]);

        // Store sequence: negative offset wrap and SW with ra=0
        @(negedge clk_x); rst = 1'b0; #1;
        clear_mems();
        dut.max.data[4] = 32'h77;
        dut.i_f.mem[0] = enc_i(6'h31, 5'd1, 5'd2, 16'hFFFF);
        dut.i_f.mem[1] = enc_i(6'h31, 5'd0, 5'd2, 16'h0004);
        @(negedge clk_x); rst = 1'b1;
        dut.id.reg_b[1] = 32'h0000_A5A5;
        dut.id.reg_b[2] = 32'd0;
        repeat (2) @(posedge clk_x);
        #1;
        check("sw_wrap_data1023", dut.max.data[1023], 32'h0000_A5A5);
        check("sw_r0_data4", dut.max.data[4], 32'd0);
        $display("seq store: data[1023]=0x%08h data[4]=0x%08h", dut.max.data[1023], dut.max.data[4]);

        // Single-instruction vector table: R1=x, R2=y, R3 pre-set to a marker
        vecs.push_back('{"add",       enc_r(6'h00, 5'd3, 5'd1, 5'd2), 32'd5, 32'd7, 3, 32'd12, 1});
        vecs.push_back('{"sub_wrap",  enc_r(6'h01, 5'd3, 5'd1, 5'd2), 32'd0, 32'd1, 3, 32'hFFFF_FFFF, 1});
        vecs.push_back('{"and",       enc_r(6'h02, 5'd3, 5'd1, 5'd2), 32'hF0F0_FFFF, 32'h0FF0_00FF, 3, 32'h00F0_00FF, 1});
        vecs.push_back('{"or",        enc_r(6'h03, 5'd3, 5'd1, 5'd2), 32'h1200, 32'h0034, 3, 32'h1234, 1});
        vecs.push_back('{"xor",       enc_r(6'h04, 5'd3, 5'd1, 5'd2), 32'hFFFF_0000, 32'h0F0F_0F0F, 3, 32'hF0F0_0F0F, 1});
        vecs.push_back('{"slt_neg",   enc_r(6'h05, 5'd3, 5'd1, 5'd2), 32'hFFFF_FFFF, 32'd1, 3, 32'd1, 1});
        vecs.push_back('{"slt_false", enc_r(6'h05, 5'd3, 5'd1, 5'd2), 32'd1, 32'hFFFF_FFFF, 3, 32'd0, 1});
        vecs.push_back('{"sll",       enc_r(6'h06, 5'd3, 5'd1, 5'd2), 32'd1, 32'h21, 3, 32'd2, 1});
        vecs.push_back('{"srl",       enc_r(6'h07, 5'd3, 5'd1, 5'd2), 32'h8000_0000, 32'h1F, 3, 32'd1, 1});
        vecs.push_back('{"f8_zero",   enc_r(6'h08, 5'd3, 5'd1, 5'd2), 32'd5, 32'd5, 3, 32'd0, 1});
        vecs.push_back('{"r0_write",  enc_r(6'h00, 5'd0, 5'd1, 5'd2), 32'd5, 32'd7, 0, 32'd0, 1});
        vecs.push_back('{"addi_neg",  enc_i(6'h10, 5'd3, 5'd1, 16'hFFFF), 32'd10, 32'd0, 3, 32'd9, 1});
        vecs.push_back('{"subi",      enc_i(6'h11, 5'd3, 5'd1, 16'h0003), 32'd2, 32'd0, 3, 32'hFFFF_FFFF, 1});
        vecs.push_back('{"slli",      enc_i(6'h16, 5'd3, 5'd1, 16'h0004), 32'd3, 32'd0, 3, 32'h30, 1});
        vecs.push_back('{"bnez_nt",   enc_i(6'h35, 5'd0, 5'd0, 16'h0005), 32'd4, 32'd0, 3, 32'hDEAD_BEEF, 1});
        vecs.push_back('{"bnez_t",    enc_i(6'h35, 5'd1, 5'd0, 16'hFFFF), 32'd4, 32'd0, 3, 32'hDEAD_BEEF, 0});
        vecs.push_back('{"beqz_wrap", enc_i(6'h34, 5'd0, 5'd0, 16'hFFFE), 32'd4, 32'd0, 3, 32'hDEAD_BEEF, 1023});
        vecs.push_back('{"lw_wrap",   enc_i(6'h30, 5'd3, 5'd1, 16'h0002), 32'h3FF, 32'd0, 3, 32'hCAFE_F00D, 1});
        vecs.push_back('{"lw_neg",    enc_i(6'h30, 5'd3, 5'd1, 16'hFFFE), 32'd0, 32'd0, 3, 32'h1122_3344, 1});
        vecs.push_back('{"nop_op20",  32'h8000_0000, 32'd1, 32'd2, 3, 32'hDEAD_BEEF, 1});
        vecs.push_back('{"hlt",       32'hFC00_0000, 32'd1, 32'd2, 3, 32'hDEAD_BEEF, 0});

        dut.max.data[1]    = 32'hCAFE_F00D;
        dut.max.data[1022] = 32'h1122_3344;
        foreach (vecs[v]) begin
            @(negedge clk_x); rst = 1'b0; #1;
            dut.i_f.mem[0] = vecs[v].instr;
            @(negedge clk_x); rst = 1'b1;
            dut.id.reg_b[1] = vecs[v].x;
            dut.id.reg_b[2] = vecs[v].y;
            dut.id.reg_b[3] = 32'hDEAD_BEEF;
            @(posedge clk_x); #1;
            check({vecs[v].name, "_val"}, dut.id.reg_b[vecs[v].dst], vecs[v].exp_val);
            check({vecs[v].name, "_pc"}, 32'(dut.pc_reg), 32'(vecs[v].exp_pc));
            $display("vec %s: r%0d=0x%08h pc=%0d", vecs[v].name, vecs[v].dst,
                     dut.id.reg_b[vecs[v].dst], dut.pc_reg);
        end

        // Random programs against the model
        for (int p = 0; p < 4; p++) begin
            @(negedge clk_x); rst = 1'b0; #1;
            for (int i = 0; i < ID; i++) m_imem[i] = 32'd0;
            for (int i = 0; i < 64; i++) begin
                int sel, off;
                sel = int'($urandom_range(0, 9));
                off = int'($urandom_range(0, 16)) - 8;
                if (sel <= 4)
                    ins = {6'($urandom_range(0, 31)), 5'($urandom_range(0, 7)),
                           5'($urandom_range(0, 7)), 16'($urandom)};
                else if (sel <= 6)
                    ins = enc_i(6'h30 + 6'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                                5'($urandom_range(0, 7)), 16'(off));
                else if (sel == 7)
                    ins = enc_i(6'h34 + 6'($urandom_range(0, 1)), 5'($urandom_range(0, 7)),
                                5'd0, 16'(off));
                else if (sel == 8)
                    ins = $urandom;
                else
                    ins = enc_i(6'h30, 5'($urandom_range(1, 7)), 5'd0, 16'($urandom_range(0, 1023)));
                m_imem[i] = ins;
            end
            if (p[0]) m_imem[63] = 32'hFC00_0000;
            for (int i = 0; i < ID; i++) dut.i_f.mem[i] = m_imem[i];
            for (int i = 0; i < DD; i++) begin
                m_data[i] = $urandom;
                dut.max.data[i] = m_data[i];
            end
            for (int i = 0; i < 32; i++) m_reg[i] = 32'd0;
            m_pc = 0;
            m_halt = 1'b0;
            @(negedge clk_x); rst = 1'b1;
            for (int c = 0; c < 200; c++) begin
                m_step();
                @(posedge clk_x); #1;
                check($sformatf("rand%0d_pc_c%0d", p, c), 32'(dut.pc_reg), 32'(m_pc));
                k = 0;
                for (int r = 31; r >= 0; r--) if (dut.id.reg_b[r] !== m_reg[r]) k = r;
                check($sformatf("rand%0d_r%0d_c%0d", p, k, c), dut.id.reg_b[k], m_reg[k]);
            end
            k = 0;
            for (int i = DD - 1; i >= 0; i--) if (dut.max.data[i] !== m_data[i]) k = i;
            check($sformatf("rand%0d_data%0d", p, k), dut.max.data[k], m_data[k]);
            check($sformatf("rand%0d_halted", p), 32'(dut.halted_reg), 32'(m_halt));
            $display("rand prog %0d: pc=%0d halted=%0d", p, dut.pc_reg, dut.halted_reg);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
